// File: rtl/thread_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : thread_scheduler_pkg
// Description : Shared types for the fetch scheduler: thread id, virtual
//               pointer, per-thread run state and boot PCs.
// Revision    : 1.0 - initial release
// ============================================================================
package thread_scheduler_pkg;

    localparam int n_threads = 4;
    localparam int TID_W     = $clog2(n_threads);

    typedef logic [TID_W-1:0] threadid_t;
    typedef logic [31:0]      vptr_t;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        BLOCKED = 1'b1
    } thread_state_t;

    // Boot PC of thread idx: each thread gets its own 4 KiB-aligned entry point.
    function automatic vptr_t boot_pc(input int unsigned idx);
        return vptr_t'((idx + 1) << 12);
    endfunction

endpackage
`default_nettype wire

// File: rtl/thread_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : thread_scheduler_if
// Description : Bundle of writeback redirect, exception, I-cache and fetch
//               signals around the fetch scheduler. master = scheduler side.
// Revision    : 1.0 - initial release
// ============================================================================
interface thread_scheduler_if
    import thread_scheduler_pkg::*;
#(
    parameter int N_THREADS = n_threads
) ();

    logic [N_THREADS-1:0] wb_redirect_en;
    vptr_t                wb_redirect_pc [N_THREADS];
    logic                 exc_en;
    threadid_t            exc_thread;
    logic                 icache_miss_en;
    threadid_t            icache_miss_thread;
    vptr_t                icache_miss_pc;
    logic                 icache_fill_en;
    logic                 fetch_stall;
    logic                 fetch_valid;
    threadid_t            fetch_thread;
    vptr_t                fetch_pc;

    modport master (
        input  wb_redirect_en, wb_redirect_pc, exc_en, exc_thread,
               icache_miss_en, icache_miss_thread, icache_miss_pc,
               icache_fill_en, fetch_stall,
        output fetch_valid, fetch_thread, fetch_pc
    );

    modport slave (
        output wb_redirect_en, wb_redirect_pc, exc_en, exc_thread,
               icache_miss_en, icache_miss_thread, icache_miss_pc,
               icache_fill_en, fetch_stall,
        input  fetch_valid, fetch_thread, fetch_pc
    );

endinterface
`default_nettype wire

// File: rtl/thread_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : thread_scheduler_rr_pick
// Description : Combinational rotating-priority picker. Searches ptr+1,
//               ptr+2, ..., ptr (mod N) and returns the first ready index.
// Revision    : 1.0 - initial release
// ============================================================================
module thread_scheduler_rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] ready,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] index
);

    logic [W-1:0] cand;

    // Walk the ring starting just after ptr; N is a power of two so the
    // W-bit add wraps naturally and k==N lands back on ptr itself.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = ptr + W'(k);
            if (!found && ready[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/thread_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : thread_scheduler
// Description : Per-cycle fetch scheduler. Keeps each thread's next-fetch PC,
//               picks one ready thread per cycle (round robin, or only the
//               exception master while exc_en is high), applies WB redirects
//               and parks threads on I-cache misses until refill.
// Revision    : 1.0 - initial release
// ============================================================================
module thread_scheduler
    import thread_scheduler_pkg::*;
#(
    parameter int N_THREADS = n_threads,
    parameter int PC_STEP   = 4
) (
    input logic                clk,
    input logic                rst,
    thread_scheduler_if.master bus
);

    thread_state_t        tstate      [N_THREADS];
    thread_state_t        tstate_nxt  [N_THREADS];
    vptr_t                next_pc     [N_THREADS];
    vptr_t                next_pc_nxt [N_THREADS];
    logic [N_THREADS-1:0] miss_hit;
    logic [N_THREADS-1:0] ready;

    threadid_t rr_ptr;
    logic      pick_found;
    threadid_t pick_index;
    logic      cand_found;
    threadid_t cand;
    logic      issue;
    logic      held_hit;

    logic      out_valid;
    threadid_t out_thread;
    vptr_t     out_pc;

    // A thread missing or being redirected this cycle must not fetch with
    // its stale PC, so both conditions remove it from selection.
    generate
        for (genvar i = 0; i < N_THREADS; i++) begin : g_ready
            assign miss_hit[i] = bus.icache_miss_en &&
                                 (bus.icache_miss_thread == threadid_t'(i));
            assign ready[i]    = (tstate[i] == RUN) && !miss_hit[i] &&
                                 !bus.wb_redirect_en[i];
        end
    endgenerate

    thread_scheduler_rr_pick #(
        .N (N_THREADS),
        .W ($bits(threadid_t))
    ) u_rr_pick (
        .ready (ready),
        .ptr   (rr_ptr),
        .found (pick_found),
        .index (pick_index)
    );

    // Exception mode bypasses round robin: only the master may fetch.
    always_comb begin
        cand_found = pick_found;
        cand       = pick_index;
        if (bus.exc_en) begin
            cand_found = ready[bus.exc_thread];
            cand       = bus.exc_thread;
        end
    end

    assign issue    = !bus.fetch_stall && cand_found;
    assign held_hit = bus.wb_redirect_en[out_thread] ||
                      (bus.icache_miss_en && (bus.icache_miss_thread == out_thread));

    // Next PC and run state per thread; later assignments take priority:
    // redirect beats miss PC beats increment, and a miss beats a fill.
    always_comb begin
        for (int i = 0; i < N_THREADS; i++) begin
            next_pc_nxt[i] = next_pc[i];
            tstate_nxt[i]  = tstate[i];
            if (issue && (cand == threadid_t'(i))) begin
                next_pc_nxt[i] = next_pc[i] + vptr_t'(PC_STEP);
            end
            if (miss_hit[i]) begin
                next_pc_nxt[i] = bus.icache_miss_pc;
            end
            if (bus.wb_redirect_en[i]) begin
                next_pc_nxt[i] = bus.wb_redirect_pc[i];
            end
            if (bus.icache_fill_en) begin
                tstate_nxt[i] = RUN;
            end
            if (miss_hit[i]) begin
                tstate_nxt[i] = BLOCKED;
            end
        end
    end

    // Per-thread state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_THREADS; i++) begin
                tstate[i]  <= RUN;
                next_pc[i] <= boot_pc(i);
            end
        end else begin
            for (int i = 0; i < N_THREADS; i++) begin
                tstate[i]  <= tstate_nxt[i];
                next_pc[i] <= next_pc_nxt[i];
            end
        end
    end

    // Fetch request register and round-robin pointer. A stall holds the
    // request, but a held request whose thread was redirected or missed is
    // stale and gets dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_thread <= '0;
            out_pc     <= '0;
            rr_ptr     <= '0;
        end else if (!bus.fetch_stall) begin
            if (cand_found) begin
                out_valid  <= 1'b1;
                out_thread <= cand;
                out_pc     <= next_pc[cand];
                rr_ptr     <= cand;
            end else begin
                out_valid  <= 1'b0;
            end
        end else if (held_hit) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.fetch_valid  = out_valid;
    assign bus.fetch_thread = out_thread;
    assign bus.fetch_pc     = out_pc;

endmodule
`default_nettype wire
